// File: rtl/izh_sched_pkg.sv
// Shared types for the time-multiplexed Izhikevich scheduler.
package izh_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    UPDATE,
    FINISH
  } state_t;

  localparam int STEP_CNT_W = 16;

endpackage

// File: rtl/izhikevich_step.sv
// Combinational Izhikevich update for one neuron in Q-format fixed point.
// Every add/subtract wraps at N bits; products are truncated after the Q shift.
module izhikevich_step #(
  parameter int N = 18,
  parameter int Q = 10
) (
  input  logic [N-1:0] v,
  input  logic [N-1:0] w,
  input  logic [N-1:0] i,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
  input  logic [N-1:0] d,
  input  logic [N-1:0] v_th,
  input  logic [N-1:0] dv_step,
  input  logic [N-1:0] dw_step,
  output logic [N-1:0] v_next,
  output logic [N-1:0] w_next,
  output logic         spike
);

  // 0.04, 5 and 140 in Q format; 140 does not fit N=18 and wraps, which is
  // harmless because every sum it feeds wraps as well.
  localparam logic [N-1:0] K_004 = N'(((4 << Q) + 50) / 100);
  localparam logic [N-1:0] K_5   = N'(5 << Q);
  localparam logic [N-1:0] K_140 = N'(140 << Q);

  function automatic logic [N-1:0] fmul(input logic [N-1:0] x, input logic [N-1:0] y);
    return N'(((2*N)'(signed'(x)) * (2*N)'(signed'(y))) >>> Q);
  endfunction

  logic [N-1:0] dv;
  logic [N-1:0] dw;

  // dv = 0.04 v^2 + 5 v + 140 - w + i ; dw = a (b v - w)
  always_comb begin
    dv    = fmul(K_004, fmul(v, v)) + fmul(K_5, v) + K_140 - w + i;
    dw    = fmul(a, fmul(b, v) - w);
    spike = $signed(v) > $signed(v_th);
    if (spike) begin
      v_next = c;
      w_next = w + d;
    end else begin
      v_next = v + fmul(dv, dv_step);
      w_next = w + fmul(dw, dw_step);
    end
  end

endmodule

// File: rtl/izhikevich_scheduler.sv
// Sweeps NUM_NEURONS neurons through one shared izhikevich_step per timestep,
// two cycles per neuron (LOAD operands, UPDATE writeback), then pulses done.
module izhikevich_scheduler
  import izh_sched_pkg::*;
#(
  parameter int N           = 18,
  parameter int Q           = 10,
  parameter int NUM_NEURONS = 8,
  parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [N-1:0]          cfg_v,
  input  logic [N-1:0]          cfg_w,
  input  logic [N-1:0]          cfg_i,
  input  logic [N-1:0]          a,
  input  logic [N-1:0]          b,
  input  logic [N-1:0]          c,
  input  logic [N-1:0]          d,
  input  logic [N-1:0]          v_th,
  input  logic [N-1:0]          dv_step,
  input  logic [N-1:0]          dw_step,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [N-1:0]          rd_v,
  output logic [N-1:0]          rd_w,
  output logic                  busy,
  output logic                  done,
  output logic [NUM_NEURONS-1:0] spike_vec,
  output logic [STEP_CNT_W-1:0] step_count,
  output logic                  cfg_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  state_t           state;
  state_t           state_nx;
  logic [IDX_W-1:0] idx;

  logic [N-1:0] v_mem [NUM_NEURONS];
  logic [N-1:0] w_mem [NUM_NEURONS];
  logic [N-1:0] i_mem [NUM_NEURONS];

  logic [N-1:0] op_v;
  logic [N-1:0] op_w;
  logic [N-1:0] op_i;
  logic [N-1:0] v_next;
  logic [N-1:0] w_next;
  logic         spike;

  izhikevich_step #(.N(N), .Q(Q)) u_step (
    .v       (op_v),
    .w       (op_w),
    .i       (op_i),
    .a       (a),
    .b       (b),
    .c       (c),
    .d       (d),
    .v_th    (v_th),
    .dv_step (dv_step),
    .dw_step (dw_step),
    .v_next  (v_next),
    .w_next  (w_next),
    .spike   (spike)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: every path assigns state_nx first, so no latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    state_nx = UPDATE;
      UPDATE:  state_nx = (idx == LAST_IDX) ? FINISH : LOAD;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == LOAD) || (state == UPDATE);
  assign done = (state == FINISH);
  assign rd_v = v_mem[rd_idx];
  assign rd_w = w_mem[rd_idx];

  // NOTE: the state arrays are flops, not RAM, because reset must clear them;
  // all sequential writes use <= so LOAD/UPDATE see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_NEURONS; k++) begin
        v_mem[k] <= '0;
        w_mem[k] <= '0;
        i_mem[k] <= '0;
      end
      idx        <= '0;
      op_v       <= '0;
      op_w       <= '0;
      op_i       <= '0;
      spike_vec  <= '0;
      step_count <= '0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_err <= busy && (start || cfg_we);
      unique case (state)
        IDLE: begin
          if (cfg_we) begin
            v_mem[cfg_idx] <= cfg_v;
            w_mem[cfg_idx] <= cfg_w;
            i_mem[cfg_idx] <= cfg_i;
          end
          if (start) begin
            idx       <= '0;
            spike_vec <= '0;
          end
        end
        LOAD: begin
          op_v <= v_mem[idx];
          op_w <= w_mem[idx];
          op_i <= i_mem[idx];
        end
        UPDATE: begin
          v_mem[idx]     <= v_next;
          w_mem[idx]     <= w_next;
          spike_vec[idx] <= spike;
          idx            <= idx + IDX_W'(1);
        end
        FINISH:  step_count <= step_count + STEP_CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_izhikevich_scheduler.sv
// Directed-plus-random bench for izhikevich_scheduler against an integer
// reference model of the Izhikevich step in Q10 with 18-bit wraparound.
module tb_izhikevich_scheduler;

  localparam int N  = 18;
  localparam int NN = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [N-1:0]  cfg_v, cfg_w, cfg_i;
  logic [N-1:0]  a, b, c, d, v_th, dv_step, dw_step;
  logic [IW-1:0] rd_idx;
  logic [N-1:0]  rd_v, rd_w;
  logic          busy, done, cfg_err;
  logic [NN-1:0] spike_vec;
  logic [15:0]   step_count;

  izhikevich_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_v      (cfg_v),
    .cfg_w      (cfg_w),
    .cfg_i      (cfg_i),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .v_th       (v_th),
    .dv_step    (dv_step),
    .dw_step    (dw_step),
    .rd_idx     (rd_idx),
    .rd_v       (rd_v),
    .rd_w       (rd_w),
    .busy       (busy),
    .done       (done),
    .spike_vec  (spike_vec),
    .step_count (step_count),
    .cfg_err    (cfg_err)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: signed integers already reduced to the 18-bit range.
  int            mv [NN];
  int            mw [NN];
  int            mi [NN];
  logic [NN-1:0] mspk;
  int            msteps;
  int            pa, pb, pc, pd, pth, pdvs, pdws;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] u18(input int x);
    return {14'd0, 18'(x)};
  endfunction

  function automatic int wrap(input longint x);
    longint m;
    m = x & 64'h3FFFF;
    if (m >= 64'h20000) m = m - 64'h40000;
    return int'(m);
  endfunction

  // Q10 product: exact product, floor-divide by 1024, wrap to 18 bits.
  function automatic int fmul(input int x, input int y);
    return wrap((longint'(x) * longint'(y)) >>> 10);
  endfunction

  function automatic int rnd18();
    return int'($urandom_range(0, 262143)) - 131072;
  endfunction

  task automatic model_sweep();
    int v, w, i, dv, dw;
    for (int k = 0; k < NN; k++) begin
      v = mv[k];
      w = mw[k];
      i = mi[k];
      if (v > pth) begin
        mv[k]   = pc;
        mw[k]   = wrap(w + pd);
        mspk[k] = 1'b1;
      end else begin
        dv      = wrap(fmul(41, fmul(v, v)) + fmul(5 * 1024, v) + 140 * 1024 - w + i);
        dw      = fmul(pa, wrap(fmul(pb, v) - w));
        mv[k]   = wrap(v + fmul(dv, pdvs));
        mw[k]   = wrap(w + fmul(dw, pdws));
        mspk[k] = 1'b0;
      end
    end
    msteps++;
  endtask

  task automatic model_clear();
    for (int k = 0; k < NN; k++) begin
      mv[k] = 0;
      mw[k] = 0;
      mi[k] = 0;
    end
    mspk   = '0;
    msteps = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_arrays(input string tag);
    for (int k = 0; k < NN; k++) begin
      rd_idx = IW'(k);
      #1;
      check($sformatf("%s rd_v[%0d]", tag, k), u18(rd_v), u18(mv[k]));
      check($sformatf("%s rd_w[%0d]", tag, k), u18(rd_w), u18(mw[k]));
    end
  endtask

  task automatic set_cfg(input int k, input int v, input int w, input int i);
    cfg_idx = IW'(k);
    cfg_v   = 18'(v);
    cfg_w   = 18'(w);
    cfg_i   = 18'(i);
  endtask

  task automatic cfg_write(input int k, input int v, input int w, input int i);
    set_cfg(k, v, w, i);
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    mv[k] = v;
    mw[k] = w;
    mi[k] = i;
  endtask

  // One full sweep with cycle-accurate busy/done/cfg_err checks. co_write
  // issues the already-staged cfg write together with start; we_cyc/st_cyc
  // inject illegal cfg_we/start at that cycle offset after the start cycle.
  task automatic run_sweep(input string tag, input bit co_write, input int we_cyc, input int st_cyc);
    if (co_write) begin
      cfg_we = 1'b1;
      mv[int'(cfg_idx)] = int'(signed'(cfg_v));
      mw[int'(cfg_idx)] = int'(signed'(cfg_w));
      mi[int'(cfg_idx)] = int'(signed'(cfg_i));
    end
    start = 1'b1;
    tick();
    start  = 1'b0;
    cfg_we = 1'b0;
    model_sweep();
    for (int cyc = 1; cyc <= 2 * NN + 1; cyc++) begin
      check($sformatf("%s busy@T+%0d", tag, cyc), {31'd0, busy}, {31'd0, cyc <= 2 * NN});
      check($sformatf("%s done@T+%0d", tag, cyc), {31'd0, done}, {31'd0, cyc == 2 * NN + 1});
      check($sformatf("%s cfg_err@T+%0d", tag, cyc), {31'd0, cfg_err},
            {31'd0, (cyc - 1 == we_cyc) || (cyc - 1 == st_cyc)});
      cfg_we = (cyc == we_cyc);
      start  = (cyc == st_cyc);
      if (cyc == we_cyc) set_cfg(3, rnd18(), rnd18(), rnd18());
      tick();
      cfg_we = 1'b0;
      start  = 1'b0;
    end
    check({tag, " busy_after"}, {31'd0, busy}, 32'd0);
    check({tag, " step_count"}, {16'd0, step_count}, 32'(msteps & 16'hFFFF));
    check({tag, " spike_vec"}, {24'd0, spike_vec}, {24'd0, mspk});
    check_arrays(tag);
  endtask

  initial begin
    int pulses;
    rst = 1'b1; start = 1'b0; cfg_we = 1'b0; rd_idx = '0;
    set_cfg(0, 0, 0, 0);
    pa = 20; pb = 205; pc = -66560; pd = 8192; pth = 30720; pdvs = 256; pdws = 256;
    a = 18'(pa); b = 18'(pb); c = 18'(pc); d = 18'(pd);
    v_th = 18'(pth); dv_step = 18'(pdvs); dw_step = 18'(pdws);
    model_clear();
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state, then a few idle cycles with busy low
    check("rst spike_vec", {24'd0, spike_vec}, 32'd0);
    check("rst step_count", {16'd0, step_count}, 32'd0);
    check("rst cfg_err", {31'd0, cfg_err}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check_arrays("rst");
    for (int k = 0; k < 3; k++) begin
      check($sformatf("idle busy %0d", k), {31'd0, busy}, 32'd0);
      tick();
    end

    // Threshold crossing on neuron 2, sub-threshold neuron 5
    cfg_write(2, 31744, 0, 0);
    cfg_write(5, -66560, -13312, 10240);
    run_sweep("thresh", 1'b0, -10, -10);
    rd_idx = 3'd2;
    #1;
    check("thresh rd_v[2]", {14'd0, rd_v}, 32'h2FC00);
    check("thresh rd_w[2]", {14'd0, rd_w}, 32'd8192);
    check("thresh spike_vec", {24'd0, spike_vec}, 32'h04);
    check("sub spike_vec[5]", {31'd0, spike_vec[5]}, 32'd0);

    // Random state, including a write issued in the same cycle as start
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 3; k++)
        cfg_write(int'($urandom_range(0, NN - 1)), rnd18(), rnd18(), rnd18());
      set_cfg(int'($urandom_range(0, NN - 1)), rnd18(), rnd18(), rnd18());
      run_sweep($sformatf("rand%0d", s), s == 1, -10, -10);
    end

    // Illegal cfg_we (neuron 3) and start while busy
    run_sweep("collide", 1'b0, 5, 9);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("collide no_resweep %0d", k), {31'd0, busy}, 32'd0);
      tick();
    end

    // Reset seven cycles into a sweep
    cfg_write(1, rnd18(), rnd18(), rnd18());
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst spike_vec", {24'd0, spike_vec}, 32'd0);
    check("midrst step_count", {16'd0, step_count}, 32'd0);
    check_arrays("midrst");
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      if (done || busy) pulses++;
      tick();
    end
    check("midrst no_done", pulses, 32'd0);

    // Recovery sweep after the abort
    cfg_write(4, 40000, 1000, 2048);
    cfg_write(6, -70000, -14000, 20000);
    run_sweep("recover", 1'b0, -10, -10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
